// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
// Module : dcache_if
// Brief  : Core/memory side signal bundle for the data cache controller.
// Rev    : 1.0  initial release
// ============================================================================
interface dcache_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
);
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   stall;
    logic                   hit;
    logic                   cache_rd_en;
    logic                   cache_wr_en;
    logic                   cache_fill_en;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [OFFSET_BITS-1:0] fill_offset;
    logic                   mem_rd_req;
    logic                   mem_wr_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ready;

    // master: core decoder/ALU plus main memory; slave: the cache controller
    modport master (
        output mem_read, mem_write, addr, mem_ready,
        input  stall, hit, cache_rd_en, cache_wr_en, cache_fill_en,
               fill_index, fill_offset, mem_rd_req, mem_wr_req, mem_addr
    );
    modport slave (
        input  mem_read, mem_write, addr, mem_ready,
        output stall, hit, cache_rd_en, cache_wr_en, cache_fill_en,
               fill_index, fill_offset, mem_rd_req, mem_wr_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module : dcache_controller
// Brief  : Direct-mapped, write-through, no-write-allocate data cache sequencer
//          with multi-word block refill and core stall generation.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_controller #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dcache_if.slave   bus
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_arr_q [LINES];
    logic [TAG_BITS-1:0]    tag_arr_d [LINES];

    logic [TAG_BITS-1:0]    w_req_tag;
    logic [INDEX_BITS-1:0]  w_req_index;
    logic [TAG_BITS-1:0]    w_lat_tag;
    logic [INDEX_BITS-1:0]  w_lat_index;
    logic                   w_is_read;
    logic                   w_is_write;
    logic                   w_lookup_hit;

    logic                   w_stall;
    logic                   w_hit;
    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_fill_en;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [OFFSET_BITS-1:0] w_fill_offset;
    logic                   w_mem_rd_req;
    logic                   w_mem_wr_req;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;

    assign w_req_tag    = bus.addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_req_index  = bus.addr[OFFSET_BITS +: INDEX_BITS];
    assign w_lat_tag    = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_lat_index  = addr_q[OFFSET_BITS +: INDEX_BITS];
    // A store wins when the decoder raises both strobes
    assign w_is_write   = bus.mem_write;
    assign w_is_read    = bus.mem_read & ~bus.mem_write;
    assign w_lookup_hit = valid_q[w_req_index] && (tag_arr_q[w_req_index] == w_req_tag);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        valid_d       = valid_q;
        tag_arr_d     = tag_arr_q;
        w_stall       = 1'b0;
        w_hit         = 1'b0;
        w_rd_en       = 1'b0;
        w_wr_en       = 1'b0;
        w_fill_en     = 1'b0;
        w_fill_index  = '0;
        w_fill_offset = '0;
        w_mem_rd_req  = 1'b0;
        w_mem_wr_req  = 1'b0;
        w_mem_addr    = '0;

        case (state_q)
            S_IDLE: begin
                if (w_is_write) begin
                    w_stall = 1'b1;
                    w_wr_en = w_lookup_hit;
                    addr_d  = bus.addr;
                    state_d = S_WRITE;
                end else if (w_is_read) begin
                    if (w_lookup_hit) begin
                        w_rd_en = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        addr_d  = bus.addr;
                        cnt_d   = '0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                w_stall       = 1'b1;
                w_mem_rd_req  = 1'b1;
                w_mem_addr    = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], cnt_q};
                w_fill_index  = w_lat_index;
                w_fill_offset = cnt_q;
                if (bus.mem_ready) begin
                    w_fill_en = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    // The line only becomes valid once every word has landed
                    if (cnt_q == LAST_WORD) begin
                        tag_arr_d[w_lat_index] = w_lat_tag;
                        valid_d[w_lat_index]   = 1'b1;
                        state_d                = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                w_stall      = 1'b1;
                w_mem_wr_req = 1'b1;
                w_mem_addr   = addr_q;
                if (bus.mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_rd_en = w_is_read;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        w_hit = (bus.mem_read | bus.mem_write) & w_lookup_hit;

        // Requests must fall the moment reset is asserted, not at the next edge
        if (rst) begin
            w_stall       = 1'b0;
            w_hit         = 1'b0;
            w_rd_en       = 1'b0;
            w_wr_en       = 1'b0;
            w_fill_en     = 1'b0;
            w_fill_index  = '0;
            w_fill_offset = '0;
            w_mem_rd_req  = 1'b0;
            w_mem_wr_req  = 1'b0;
            w_mem_addr    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Tags are qualified by valid, so the array carries no reset
    always_ff @(posedge clk) begin
        tag_arr_q <= tag_arr_d;
    end

    assign bus.stall         = w_stall;
    assign bus.hit           = w_hit;
    assign bus.cache_rd_en   = w_rd_en;
    assign bus.cache_wr_en   = w_wr_en;
    assign bus.cache_fill_en = w_fill_en;
    assign bus.fill_index    = w_fill_index;
    assign bus.fill_offset   = w_fill_offset;
    assign bus.mem_rd_req    = w_mem_rd_req;
    assign bus.mem_wr_req    = w_mem_wr_req;
    assign bus.mem_addr      = w_mem_addr;
endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_controller
// Brief  : Directed scenarios plus randomized traffic against a block-level
//          cache model for dcache_controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dcache_controller;
    localparam int AW = 10;
    localparam int IB = 5;
    localparam int OB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dcache_if #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB)) bus ();

    dcache_controller #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {stall, hit, cache_rd_en, cache_wr_en, cache_fill_en, mem_rd_req, mem_wr_req}
    logic [6:0] flags;
    assign flags = {bus.stall, bus.hit, bus.cache_rd_en, bus.cache_wr_en,
                    bus.cache_fill_en, bus.mem_rd_req, bus.mem_wr_req};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic mem_word(input int waits);
        for (int k = 0; k <= waits; k++) begin
            bus.mem_ready = (k == waits);
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.addr = 10'h016; bus.mem_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({flags, bus.mem_addr, bus.fill_index, bus.fill_offset} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b mem_addr=%h want all zero", flags, bus.mem_addr);
        end
        tick();
        sample();
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL reset_held got %b want 0000000", flags);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        sample();
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL no_request got %b want 0000000", flags);
        end
        tick();
    endtask

    task automatic test_cold_read();
        logic [6:0] exp;
        bus.mem_read = 1'b1; bus.addr = 10'h016;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL cold_entry got %b want 1000000", flags);
        end
        tick();
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k <= 2; k++) begin
                bus.mem_ready = (k == 2);
                sample();
                exp = {1'b1, 3'b000, (k == 2), 1'b1, 1'b0};
                checks++;
                if (flags !== exp) begin
                    errors++;
                    $display("FAIL cold_refill_flags w=%0d k=%0d got %b want %b", w, k, flags, exp);
                end
                checks++;
                if ({bus.mem_addr, bus.fill_index, bus.fill_offset} !== {10'(20 + w), 5'd5, 2'(w)}) begin
                    errors++;
                    $display("FAIL cold_refill_addr w=%0d got addr=%h idx=%0d off=%0d want addr=%h idx=5 off=%0d",
                             w, bus.mem_addr, bus.fill_index, bus.fill_offset, 10'(20 + w), w);
                end
                tick();
            end
        end
        bus.mem_ready = 1'b0;
        sample();
        checks++;
        if (flags !== 7'b0110000) begin
            errors++;
            $display("FAIL cold_done got %b want 0110000", flags);
        end
        tick();
        bus.mem_read = 1'b0;
        sample();
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL cold_back_idle got %b want 0000000", flags);
        end
        tick();
    endtask

    task automatic test_read_hit();
        bus.mem_read = 1'b1; bus.addr = 10'h015;
        sample();
        checks++;
        if (flags !== 7'b0110000) begin
            errors++;
            $display("FAIL read_hit got %b want 0110000", flags);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_write_hit();
        bus.mem_write = 1'b1; bus.addr = 10'h017;
        sample();
        checks++;
        if (flags !== 7'b1101000) begin
            errors++;
            $display("FAIL write_hit_entry got %b want 1101000", flags);
        end
        tick();
        for (int k = 0; k <= 2; k++) begin
            bus.mem_ready = (k == 2);
            sample();
            checks++;
            if ({flags, bus.mem_addr} !== {7'b1100001, 10'h017}) begin
                errors++;
                $display("FAIL write_hit_mem k=%0d got %b addr=%h want 1100001 addr=017", k, flags, bus.mem_addr);
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        sample();
        checks++;
        if (flags !== 7'b0100000) begin
            errors++;
            $display("FAIL write_hit_done got %b want 0100000", flags);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_write_miss();
        bus.mem_write = 1'b1; bus.mem_read = 1'b1; bus.addr = 10'h117;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL write_miss_entry got %b want 1000000", flags);
        end
        tick();
        for (int k = 0; k <= 1; k++) begin
            bus.mem_ready = (k == 1);
            sample();
            checks++;
            if ({flags, bus.mem_addr} !== {7'b1000001, 10'h117}) begin
                errors++;
                $display("FAIL write_miss_mem k=%0d got %b addr=%h want 1000001 addr=117", k, flags, bus.mem_addr);
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        sample();
        checks++;
        if (flags !== 7'b0) begin
            errors++;
            $display("FAIL write_miss_done got %b want 0000000", flags);
        end
        tick();
        bus.mem_write = 1'b0; bus.mem_read = 1'b1; bus.addr = 10'h016;
        sample();
        checks++;
        if (flags !== 7'b0110000) begin
            errors++;
            $display("FAIL no_allocate_read got %b want 0110000", flags);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_conflict();
        bus.mem_read = 1'b1; bus.addr = 10'h116;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL conflict_entry got %b want 1000000", flags);
        end
        tick();
        sample();
        checks++;
        if (bus.mem_addr !== 10'h114) begin
            errors++;
            $display("FAIL conflict_first_addr got %h want 114", bus.mem_addr);
        end
        for (int w = 0; w < 4; w++) mem_word(w % 2);
        sample();
        checks++;
        if (flags !== 7'b0110000) begin
            errors++;
            $display("FAIL conflict_done got %b want 0110000", flags);
        end
        tick();
        bus.addr = 10'h016;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL evicted_read got %b want 1000000", flags);
        end
        tick();
        sample();
        checks++;
        if (bus.mem_addr !== 10'h014) begin
            errors++;
            $display("FAIL evicted_refill_addr got %h want 014", bus.mem_addr);
        end
        for (int w = 0; w < 4; w++) mem_word(0);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_read = 1'b1; bus.addr = 10'h016;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_entry got %b want 1000000", flags);
        end
        tick();
        mem_word(0);
        mem_word(1);
        sample();
        checks++;
        if ({flags, bus.fill_offset} !== {7'b1000010, 2'd2}) begin
            errors++;
            $display("FAIL mid_before_reset got %b off=%0d want 1000010 off=2", flags, bus.fill_offset);
        end
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({flags, bus.mem_addr} !== '0) begin
            errors++;
            $display("FAIL mid_reset_drop got %b addr=%h want 0000000 addr=000", flags, bus.mem_addr);
        end
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        sample();
        checks++;
        if (flags !== 7'b1000000) begin
            errors++;
            $display("FAIL mid_line_invalid got %b want 1000000", flags);
        end
        tick();
        sample();
        checks++;
        if ({bus.mem_addr, bus.fill_offset} !== {10'h014, 2'd0}) begin
            errors++;
            $display("FAIL mid_restart got addr=%h off=%0d want 014 off=0", bus.mem_addr, bus.fill_offset);
        end
        for (int w = 0; w < 4; w++) mem_word(1);
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int         m_blk [32];
        logic [9:0] a;
        logic [6:0] exp;
        int         kind, wt, blk, idx;
        bit         mhit;
        for (int i = 0; i < 32; i++) m_blk[i] = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int op = 0; op < 150; op++) begin
            a    = 10'(($urandom_range(0, 3) << 7) | ($urandom_range(4, 6) << 2) | $urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            blk  = int'(a) / 4;
            idx  = blk % 32;
            mhit = (m_blk[idx] == blk);
            bus.addr      = a;
            bus.mem_read  = (kind == 1 || kind == 3);
            bus.mem_write = (kind >= 2);
            bus.mem_ready = 1'($urandom_range(0, 1));
            sample();
            if (kind == 0) exp = 7'b0;
            else if (kind == 1) exp = mhit ? 7'b0110000 : 7'b1000000;
            else exp = {1'b1, mhit, 1'b0, mhit, 3'b000};
            checks++;
            if (flags !== exp) begin
                errors++;
                $display("FAIL rand_entry op=%0d kind=%0d addr=%h got %b want %b", op, kind, a, flags, exp);
            end
            if (kind == 1 && !mhit) begin
                tick();
                for (int w = 0; w < 4; w++) begin
                    wt = $urandom_range(0, 2);
                    for (int k = 0; k <= wt; k++) begin
                        bus.mem_ready = (k == wt);
                        sample();
                        exp = {1'b1, 3'b000, (k == wt), 1'b1, 1'b0};
                        checks++;
                        if ({flags, bus.mem_addr, bus.fill_index, bus.fill_offset} !==
                            {exp, 10'(blk * 4 + w), 5'(idx), 2'(w)}) begin
                            errors++;
                            $display("FAIL rand_refill op=%0d w=%0d got %b addr=%h idx=%0d off=%0d want %b addr=%h idx=%0d off=%0d",
                                     op, w, flags, bus.mem_addr, bus.fill_index, bus.fill_offset,
                                     exp, 10'(blk * 4 + w), idx, w);
                        end
                        tick();
                    end
                end
                m_blk[idx]    = blk;
                bus.mem_ready = 1'b0;
                sample();
                checks++;
                if (flags !== 7'b0110000) begin
                    errors++;
                    $display("FAIL rand_refill_done op=%0d got %b want 0110000", op, flags);
                end
            end else if (kind >= 2) begin
                tick();
                wt = $urandom_range(0, 2);
                for (int k = 0; k <= wt; k++) begin
                    bus.mem_ready = (k == wt);
                    sample();
                    exp = {1'b1, mhit, 4'b0000, 1'b1};
                    checks++;
                    if ({flags, bus.mem_addr} !== {exp, a}) begin
                        errors++;
                        $display("FAIL rand_write op=%0d got %b addr=%h want %b addr=%h", op, flags, bus.mem_addr, exp, a);
                    end
                    tick();
                end
                bus.mem_ready = 1'b0;
                sample();
                exp = {1'b0, mhit, 5'b00000};
                checks++;
                if (flags !== exp) begin
                    errors++;
                    $display("FAIL rand_write_done op=%0d got %b want %b", op, flags, exp);
                end
            end
            tick();
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        bus.addr = '0;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing controller for the data cache in the single-cycle RISC-V core.
- Takes the main decoder's MemRead/MemWrite plus the ALU word address. Owns the tag and valid arrays; drives the external data-array enables and the main-memory handshake.
- Cache organisation: direct-mapped, write-through, no-write-allocate, multi-word block refill.
- Freezes the core through `stall` while memory traffic is outstanding.

Parameters:
- ADDR_WIDTH, 10, word address width (tag = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS).
- INDEX_BITS, 5, cache line index width (32 lines).
- OFFSET_BITS, 2, word-in-block width (BLOCK_WORDS = 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load request from main decoder (MemRead).
- mem_write  in  1  store request from main decoder (MemWrite).
- addr  in  ADDR_WIDTH  word address from ALU.
- stall  out  1  freeze PC/pipeline of core.
- hit  out  1  tag match and valid for current request address.
- cache_rd_en  out  1  data array read enable (load served from cache).
- cache_wr_en  out  1  data array write of CPU store data.
- cache_fill_en  out  1  data array write of memory word during refill.
- fill_index  out  INDEX_BITS  line written during refill.
- fill_offset  out  OFFSET_BITS  word written during refill.
- mem_rd_req  out  1  main-memory word read request.
- mem_wr_req  out  1  main-memory word write request.
- mem_addr  out  ADDR_WIDTH  main-memory word address.
- mem_ready  in  1  memory completed current word this cycle.

Behaviour:
- Field split: addr = {tag, index, offset}. hit = valid[index] && tag_arr[index]==tag, combinational.
- While rst is high: FSM=IDLE, word counter=0, all valid bits=0, latched address=0, all outputs 0.
- Requests: mem_write has priority if both mem_read and mem_write are high. With no request, all outputs are 0.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - Read hit: stall=0, cache_rd_en=1; zero added latency; stay IDLE.
  - Read miss: stall=1 in the same cycle; latch addr; counter=0; next state REFILL.
  - Write: stall=1; latch addr; next state WRITE. On write hit, cache_wr_en=1 for this cycle only. On write miss, the cache is untouched.
- REFILL:
  - stall=1, mem_rd_req=1.
  - mem_addr = {latched tag, latched index, counter}; fill_index = latched index; fill_offset = counter.
  - On mem_ready: cache_fill_en=1 in that cycle; counter increments (wraps mod BLOCK_WORDS).
  - On mem_ready with counter==BLOCK_WORDS-1: write tag_arr and set valid for the latched index; next state DONE.
  - Without mem_ready, all outputs are held stable.
- WRITE:
  - stall=1, mem_wr_req=1, mem_addr = latched addr. Hold until mem_ready, then go to DONE.
- DONE:
  - stall=0 for exactly one cycle, which lets the core retire the instruction; no memory requests are issued.
  - For a read, cache_rd_en=1 and hit=1 are guaranteed.
  - Next state is IDLE unconditionally, so a held request is never reissued.
- Latency:
  - Read miss: stall cycles = sum of the BLOCK_WORDS memory waits + 1 (the entry cycle). Data is delivered in DONE.
  - Store: 1 + memory wait, then DONE.
- Reset mid-operation: aborts the refill or write immediately. The line is left invalid and requests drop asynchronously.
- Partial refill: valid is never set until all BLOCK_WORDS words have been filled.
- The tag array needs no reset; valid does.

Test Plan:
- Cold read of 0x016, mem_ready pulsed once per word after 2 wait cycles:
  - stall rises the same cycle.
  - mem_addr steps 0x014, 0x015, 0x016, 0x017, with cache_fill_en on each mem_ready and fill_index=5, fill_offset=0..3.
  - Then one DONE cycle with stall=0, hit=1, cache_rd_en=1, then IDLE.
- Read 0x015 after that refill: stall=0, hit=1, cache_rd_en=1 in the same cycle; no mem_rd_req.
- Write 0x017 (hit): cache_wr_en pulses one cycle; mem_wr_req=1 with mem_addr=0x017 held until mem_ready; then DONE with stall=0.
- Write 0x117 (index 5, different tag): cache_wr_en stays 0 and mem_wr_req is issued; a following read of 0x016 still hits.
- Read 0x116 (conflict): refills line 5 from 0x114..0x117; a later read of 0x016 misses and refills again.
- Assert rst after two refill words of 0x016:
  - stall, mem_rd_req and cache_fill_en go to 0 immediately.
  - After release, a read of 0x016 misses and the refill restarts at offset 0.
